// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: parallel capture, serial shift, or capture followed by shift.
// Optional SCAN_PARITY_EN adds parity_out, the running XOR of bits shifted out.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk_signal,
    input  logic                 rst_n_signal,
    input  logic                 start_in,
    input  logic [1:0]           op_in,
    input  logic                 abort_in,
    input  logic [CHAIN_LEN-1:0] par_in,
    input  logic                 scan_in,
    output logic                 scan_out,
    output logic [CHAIN_LEN-1:0] par_out,
    output logic                 scan_en_out,
    output logic                 busy_out,
    output logic                 done_out,
`ifdef SCAN_PARITY_EN
    output logic                 parity_out,
`endif
    output logic                 err_out
);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] OpCapture  = 2'b00;
    localparam logic [1:0] OpShift    = 2'b01;
    localparam logic [1:0] OpCapShift = 2'b10;
    localparam logic [1:0] OpIllegal  = 2'b11;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [CHAIN_LEN-1:0] chain_q, chain_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 err_q, err_d;
`ifdef SCAN_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_ff @(posedge clk_signal or negedge rst_n_signal) begin
        if (!rst_n_signal) begin
            state_q <= StIdle;
            chain_q <= '0;
            cnt_q   <= '0;
            op_q    <= OpCapture;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

`ifdef SCAN_PARITY_EN
    always_ff @(posedge clk_signal or negedge rst_n_signal) begin
        if (!rst_n_signal) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = 1'b0;
`ifdef SCAN_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    unique case (op_in)
                        OpCapture, OpCapShift: begin
                            op_d    = op_in;
                            state_d = StCapture;
`ifdef SCAN_PARITY_EN
                            parity_d = 1'b0;
`endif
                        end
                        OpShift: begin
                            op_d    = op_in;
                            cnt_d   = '0;
                            state_d = StShift;
`ifdef SCAN_PARITY_EN
                            parity_d = 1'b0;
`endif
                        end
                        OpIllegal: begin
                            err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            StCapture: begin
                chain_d = par_in;
                if (op_q == OpCapShift) begin
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StDone;
                end
            end

            StShift: begin
                // Abort freezes the chain with its partial contents and skips DONE.
                if (abort_in) begin
                    state_d = StIdle;
                end else begin
                    chain_d = {scan_in, chain_q[CHAIN_LEN-1:1]};
                    cnt_d   = cnt_q + 1'b1;
`ifdef SCAN_PARITY_EN
                    parity_d = parity_q ^ chain_q[0];
`endif
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign scan_out    = chain_q[0];
    assign par_out     = chain_q;
    assign scan_en_out = (state_q == StShift);
    assign busy_out    = (state_q == StCapture) || (state_q == StShift);
    assign done_out    = (state_q == StDone);
    assign err_out     = err_q;
`ifdef SCAN_PARITY_EN
    assign parity_out  = parity_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed self-checking bench for scan_chain_ctrl (CHAIN_LEN=8).
// Honours SCAN_PARITY_EN to connect and check parity_out.
module tb_scan_chain_ctrl;

    logic       clk_signal = 1'b0;
    logic       rst_n_signal = 1'b0;
    logic       start_in = 1'b0;
    logic [1:0] op_in = 2'b00;
    logic       abort_in = 1'b0;
    logic [7:0] par_in = 8'h00;
    logic       scan_in = 1'b0;
    logic       scan_out;
    logic [7:0] par_out;
    logic       scan_en_out;
    logic       busy_out;
    logic       done_out;
    logic       err_out;
    logic       par_bit;
    logic [13:0] all_out;

    int n_cmp  = 0;
    int n_fail = 0;

    scan_chain_ctrl #(
        .CHAIN_LEN(8),
        .CNT_W    (4)
    ) dut (
        .clk_signal  (clk_signal),
        .rst_n_signal(rst_n_signal),
        .start_in    (start_in),
        .op_in       (op_in),
        .abort_in    (abort_in),
        .par_in      (par_in),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .par_out     (par_out),
        .scan_en_out (scan_en_out),
        .busy_out    (busy_out),
        .done_out    (done_out),
`ifdef SCAN_PARITY_EN
        .parity_out  (par_bit),
`endif
        .err_out     (err_out)
    );

`ifndef SCAN_PARITY_EN
    assign par_bit = 1'b0;
`endif

    assign all_out = {par_bit, scan_out, par_out, scan_en_out, busy_out, done_out, err_out};

    always #5 clk_signal = ~clk_signal;

    task automatic tick();
        @(posedge clk_signal);
        #1;
    endtask

    task automatic test_reset();
        rst_n_signal = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start_in = 1'($urandom);
            op_in    = 2'($urandom);
            abort_in = 1'($urandom);
            par_in   = 8'($urandom);
            scan_in  = 1'($urandom);
            #3;
            n_cmp++;
            if (all_out !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_outs[%0d]: got %h want 0000", i, all_out);
            end
        end
        start_in = 1'b0; op_in = 2'b00; abort_in = 1'b0; par_in = 8'h00; scan_in = 1'b0;
        tick();
        rst_n_signal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (busy_out !== 1'b0 || all_out !== 14'h0) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got %h want 0000", i, all_out);
            end
        end
    endtask

    task automatic test_capture(input logic [7:0] word);
        par_in = word; op_in = 2'b00; start_in = 1'b1;
        tick();  // cycle 1
        start_in = 1'b0;
        n_cmp++;
        if ({busy_out, done_out, scan_en_out} !== 3'b100) begin
            n_fail++;
            $display("FAIL cap_cycle1: busy/done/en got %b want 100",
                     {busy_out, done_out, scan_en_out});
        end
        tick();  // cycle 2
        n_cmp++;
        if ({busy_out, done_out} !== 2'b01 || par_out !== word) begin
            n_fail++;
            $display("FAIL cap_cycle2: busy/done got %b want 01, par_out got %h want %h",
                     {busy_out, done_out}, par_out, word);
        end
        tick();  // cycle 3
        n_cmp++;
        if ({busy_out, done_out} !== 2'b00 || par_out !== word) begin
            n_fail++;
            $display("FAIL cap_cycle3: busy/done got %b want 00, par_out got %h want %h",
                     {busy_out, done_out}, par_out, word);
        end
    endtask

    task automatic test_capture_shift();
        logic [7:0] exp_so;
        exp_so = 8'b0011_1100;  // bit i = expected scan_out in shift cycle i
        par_in = 8'h3C; op_in = 2'b10; scan_in = 1'b1; start_in = 1'b1;
        tick();  // cycle 1
        start_in = 1'b0;
        n_cmp++;
        if ({busy_out, scan_en_out, done_out} !== 3'b100) begin
            n_fail++;
            $display("FAIL cs_capture: busy/en/done got %b want 100",
                     {busy_out, scan_en_out, done_out});
        end
        for (int i = 0; i < 8; i++) begin
            tick();  // cycles 2..9
            n_cmp++;
            if ({scan_en_out, busy_out, done_out} !== 3'b110 || scan_out !== exp_so[i]) begin
                n_fail++;
                $display("FAIL cs_shift[%0d]: en/busy/done got %b want 110, scan_out got %b want %b",
                         i, {scan_en_out, busy_out, done_out}, scan_out, exp_so[i]);
            end
        end
        tick();  // cycle 10
        n_cmp++;
        if ({scan_en_out, busy_out, done_out} !== 3'b001 || par_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL cs_done: en/busy/done got %b want 001, par_out got %h want ff",
                     {scan_en_out, busy_out, done_out}, par_out);
        end
`ifdef SCAN_PARITY_EN
        n_cmp++;
        if (par_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_parity: got %b want 0", par_bit);
        end
`endif
        scan_in = 1'b0;
        tick();
        n_cmp++;
        if (done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_done_pulse: done got %b want 0", done_out);
        end
    endtask

    task automatic test_illegal();
        op_in = 2'b11; start_in = 1'b1;
        tick();
        start_in = 1'b0; op_in = 2'b00;
        n_cmp++;
        if ({err_out, busy_out, done_out} !== 3'b100 || par_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL illegal_c1: err/busy/done got %b want 100, par_out got %h want ff",
                     {err_out, busy_out, done_out}, par_out);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({err_out, busy_out, done_out} !== 3'b000 || par_out !== 8'hFF) begin
                n_fail++;
                $display("FAIL illegal_after[%0d]: err/busy/done got %b want 000, par_out %h want ff",
                         i, {err_out, busy_out, done_out}, par_out);
            end
        end
    endtask

    task automatic test_shift_abort();
        test_capture(8'hA5);
        op_in = 2'b01; scan_in = 1'b0; start_in = 1'b1;
        tick();  // cycle 1, chain A5
        start_in = 1'b0;
        n_cmp++;
        if ({scan_en_out, busy_out} !== 2'b11 || par_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL sa_c1: en/busy got %b want 11, par_out got %h want a5",
                     {scan_en_out, busy_out}, par_out);
        end
        op_in = 2'b00; start_in = 1'b1;  // ignored: not in IDLE
        tick();  // cycle 2, chain 52
        start_in = 1'b0;
        n_cmp++;
        if (par_out !== 8'h52 || scan_en_out !== 1'b1) begin
            n_fail++;
            $display("FAIL sa_c2: par_out got %h want 52, en got %b want 1", par_out, scan_en_out);
        end
`ifdef SCAN_PARITY_EN
        n_cmp++;
        if (par_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL sa_parity_c2: got %b want 1", par_bit);
        end
`endif
        tick();  // cycle 3, chain 29
        tick();  // cycle 4, chain 14
        abort_in = 1'b1;
        tick();  // cycle 5: aborted, chain held
        abort_in = 1'b0;
        n_cmp++;
        if ({busy_out, done_out, scan_en_out} !== 3'b000 || par_out !== 8'h14) begin
            n_fail++;
            $display("FAIL sa_abort: busy/done/en got %b want 000, par_out got %h want 14",
                     {busy_out, done_out, scan_en_out}, par_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({busy_out, done_out} !== 2'b00 || par_out !== 8'h14) begin
                n_fail++;
                $display("FAIL sa_idle[%0d]: busy/done got %b want 00, par_out got %h want 14",
                         i, {busy_out, done_out}, par_out);
            end
        end
`ifdef SCAN_PARITY_EN
        n_cmp++;
        if (par_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL sa_parity_end: got %b want 0", par_bit);
        end
`endif
    endtask

    task automatic test_abort_ignored_outside_shift();
        abort_in = 1'b1; par_in = 8'h5A; op_in = 2'b00; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();  // cycle 2: capture completed despite abort
        n_cmp++;
        if (done_out !== 1'b1 || par_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL abort_ignored: done got %b want 1, par_out got %h want 5a",
                     done_out, par_out);
        end
        abort_in = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        op_in = 2'b01; scan_in = 1'b1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        rst_n_signal = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== 14'h0) begin
            n_fail++;
            $display("FAIL rst_mid_shift: got %h want 0000", all_out);
        end
        tick();
        rst_n_signal = 1'b1;
        scan_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (all_out !== 14'h0) begin
                n_fail++;
                $display("FAIL rst_after[%0d]: got %h want 0000", i, all_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture(8'hA5);
        test_capture_shift();
        test_illegal();
        test_shift_abort();
        test_abort_ignored_outside_shift();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
